// File: rtl/mdu.sv
// rtl/mdu.sv - iterative multiply/divide unit with HI/LO registers
module mdu (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  input  logic        cancel,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  // MUL: {partial product high, remaining multiplier bits}
  // DIV: {partial remainder, dividend shifting into quotient}
  logic [63:0] acc_q, acc_d;
  logic [31:0] opb_q, opb_d;     // multiplicand or divisor magnitude
  logic [31:0] a_q, a_d;         // raw dividend for the divide-by-zero result
  logic        neg_res_q, neg_res_d;
  logic        neg_rem_q, neg_rem_d;
  logic        dbz_q, dbz_d;
  logic        done_q, done_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        is_signed;
  logic [31:0] mag_a, mag_b;
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic [32:0] div_diff;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;

  // Operand magnitudes and one-iteration datapath for each state
  always_comb begin
    is_signed = ~op[0];
    mag_a     = (is_signed && a[31]) ? (~a + 32'd1) : a;
    mag_b     = (is_signed && b[31]) ? (~b + 32'd1) : b;
    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
    div_shift = {acc_q[63:32], acc_q[31]};
    div_diff  = div_shift - {1'b0, opb_q};
    prod_fix  = neg_res_q ? (~acc_q + 64'd1) : acc_q;
    quo_fix   = neg_res_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
    rem_fix   = neg_rem_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
  end

  // Next-state: launch, iterate, finalize, cancel, and HI/LO moves
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    a_d       = a_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dbz_d     = dbz_q;
    done_d    = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start && !cancel) begin
          state_d   = op[1] ? S_DIV : S_MUL;
          cnt_d     = 6'd0;
          acc_d     = op[1] ? {32'd0, mag_a} : {32'd0, mag_b};
          opb_d     = op[1] ? mag_b : mag_a;
          a_d       = a;
          neg_res_d = is_signed & (a[31] ^ b[31]);
          neg_rem_d = is_signed & op[1] & a[31];
          dbz_d     = op[1] & (b == 32'd0);
        end else if (!start) begin
          // a same-cycle start always takes priority over a HI/LO move
          if (mthi) hi_d = wdata;
          if (mtlo) lo_d = wdata;
        end
      end
      S_MUL, S_DIV: begin
        if (cancel) begin
          state_d = S_IDLE;
          cnt_d   = 6'd0;
        end else if (cnt_q == 6'd32) begin
          state_d = S_IDLE;
          cnt_d   = 6'd0;
          done_d  = 1'b1;
          if (state_q == S_MUL) begin
            hi_d = prod_fix[63:32];
            lo_d = prod_fix[31:0];
          end else if (dbz_q) begin
            hi_d = a_q;
            lo_d = 32'hFFFF_FFFF;
          end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
        end else begin
          cnt_d = cnt_q + 6'd1;
          if (state_q == S_MUL) begin
            acc_d = {mul_sum, acc_q[31:1]};
          end else if (!div_diff[32]) begin
            acc_d = {div_diff[31:0], acc_q[30:0], 1'b1};
          end else begin
            acc_d = {div_shift[31:0], acc_q[30:0], 1'b0};
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 6'd0;
      end
    endcase
  end

  // State registers, cleared asynchronously by rst low
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 6'd0;
      acc_q     <= 64'd0;
      opb_q     <= 32'd0;
      a_q       <= 32'd0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      a_q       <= a_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dbz_q     <= dbz_d;
      done_q    <= done_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 clk  input  1  pipeline clock; all state changes on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-low (rst=0 resets immediately, independent of clk).
REQ-003 start  input  1  launch operation from EX stage; sampled only in IDLE.
REQ-004 op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
REQ-005 a  input  32  rs operand (multiplicand / dividend); sampled with start.
REQ-006 b  input  32  rt operand (multiplier / divisor); sampled with start.
REQ-007 mthi  input  1  write wdata to HI.
REQ-008 mtlo  input  1  write wdata to LO.
REQ-009 wdata  input  32  data for mthi/mtlo.
REQ-010 cancel  input  1  pipeline flush; aborts in-flight operation.
REQ-011 busy  output  1  operation in flight; hazard unit stalls MFHI/MFLO/MULT/DIV/MTHI/MTLO while 1.
REQ-012 done  output  1  one-cycle pulse, HI/LO just updated.
REQ-013 hi  output  32  HI register.
REQ-014 lo  output  32  LO register.

Function
REQ-015 FSM states: IDLE, MUL, DIV; one 6-bit iteration counter.
REQ-016 IDLE + start=1 at edge E: latch op/a/b, go MUL (op[1]=0) or DIV (op[1]=1), counter=0, busy=1 after E.
REQ-017 Each state runs exactly 32 iterations (one per cycle); results written to hi/lo at edge E+33; busy=0 and done=1 for the cycle after E+33; state returns to IDLE at E+33.
REQ-018 MUL: radix-2 shift-add on magnitudes, 64-bit product; hi=product[63:32], lo=product[31:0].
REQ-019 DIV: restoring shift-subtract on magnitudes; lo=quotient, hi=remainder.
REQ-020 Signed ops (MULT, DIV): operands converted to magnitude at start; product negated if signs differ; quotient negated if signs differ; remainder takes dividend sign.
REQ-021 Divide by zero (either DIV or DIVU): lo=32'hFFFFFFFF, hi=a; same 33-cycle latency.
REQ-022 DIV 32'h80000000 / 32'hFFFFFFFF: lo=32'h80000000, hi=0.
REQ-023 Unsigned ops treat a, b as 0..2^32-1 with no sign correction.
REQ-024 start while busy=1: ignored, no effect on in-flight operation.
REQ-025 mthi/mtlo in IDLE without start: hi/lo updated at next edge; done stays 0.
REQ-026 mthi/mtlo while busy=1: ignored.
REQ-027 start and mthi/mtlo same cycle in IDLE: start wins, write dropped.
REQ-028 mthi and mtlo same cycle: both registers take wdata.
REQ-029 cancel=1 while busy: return to IDLE at next edge, busy=0, done=0, hi/lo unchanged.
REQ-030 cancel=1 in the cycle of the final edge (E+33): cancel wins, hi/lo unchanged, no done.
REQ-031 cancel and start same cycle in IDLE: start ignored.
REQ-032 done never asserted except after a completed, uncancelled MUL/DIV.

Reset
REQ-033 rst=0: state=IDLE, counter=0, busy=0, done=0, hi=0, lo=0, internal operand/accumulator registers=0, asynchronously.
REQ-034 rst asserted mid-operation: operation discarded, no done pulse after release.
REQ-035 After rst released, first start accepted on first rising edge with rst=1.

Verification
REQ-036 MULT a=7 b=6 -> busy 33 cycles, done pulse, hi=0, lo=42.
REQ-037 MULT a=32'hFFFFFFFF b=32'hFFFFFFFF -> hi=0, lo=1; MULTU same operands -> hi=32'hFFFFFFFE, lo=1.
REQ-038 DIV a=-7 (32'hFFFFFFF9) b=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF; DIVU a=100 b=7 -> lo=14, hi=2.
REQ-039 DIVU a=5 b=0 -> lo=32'hFFFFFFFF, hi=5; DIV 32'h80000000/32'hFFFFFFFF -> lo=32'h80000000, hi=0.
REQ-040 mtlo wdata=32'h1234 in IDLE, then MULT 3*4 with cancel at cycle 10 -> lo=32'h1234, hi=0, no done; mthi during busy -> hi unchanged.
REQ-041 rst=0 at cycle 15 of DIV -> busy=0, hi=lo=0 immediately; no done pulse; following MULTU 2*3 -> lo=6 after 33 cycles.
